cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer_pkg.sv | 46 ++++
 rtl/cpu_sequencer_if.sv | 32 +++
 rtl/cpu_sequencer_timeout.sv | 45 ++++
 rtl/cpu_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_sequencer_pkg.sv
// cpu_sequencer_pkg
// Shared definitions for the CPU sequencer: FSM state encoding (3 bits),
// default memory timeout, and opcode-class constants plus a classifier
// used by the EXEC dispatch.
// Optional feature macro used elsewhere in this slice: WF8_SINGLE_STEP_EN.
package cpu_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH      = 3'd0,
    ST_FETCH_WAIT = 3'd1,
    ST_DECODE     = 3'd2,
    ST_EXEC       = 3'd3,
    ST_MEM        = 3'd4,
    ST_WB         = 3'd5,
    ST_HALT       = 3'd6,
    ST_FAULT      = 3'd7
  } state_t;

  localparam int INSTR_W_DEFAULT     = 8;
  localparam int MEM_TIMEOUT_DEFAULT = 15;

  // Opcode classes are decided on the upper opcode bits only.
  localparam logic [3:0] OPC_LB      = 4'b1001;  // opcode[4:1]
  localparam logic [3:0] OPC_SB      = 4'b1010;  // opcode[4:1]
  localparam logic [3:0] OPC_JMPADR  = 4'b1011;  // opcode[4:1]
  localparam logic [1:0] OPC_BRANCH  = 2'b11;    // opcode[4:3]

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_LOAD   = 3'd1,
    CLS_STORE  = 3'd2,
    CLS_JUMP   = 3'd3,
    CLS_BRANCH = 3'd4
  } opc_class_t;

  function automatic opc_class_t opc_class(input logic [4:0] opc);
    opc_class_t cls;
    cls = CLS_ALU;
    if (opc[4:1] == OPC_LB)          cls = CLS_LOAD;
    else if (opc[4:1] == OPC_SB)     cls = CLS_STORE;
    else if (opc[4:1] == OPC_JMPADR) cls = CLS_JUMP;
    else if (opc[4:3] == OPC_BRANCH) cls = CLS_BRANCH;
    return cls;
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if
// Memory handshake bundle between the sequencer (master) and memory (slave).
//   instr_in     : instruction byte returned by memory
//   mem_ready    : memory accepts/returns the current access this cycle
//   mem_req      : access request, held until mem_ready
//   mem_addr_sel : 0 = PC drives address, 1 = ALU result drives address
//   mem_write    : store strobe, qualified by mem_req
interface cpu_sequencer_if #(
  parameter int INSTR_W = 8
);
  logic [INSTR_W-1:0] instr_in;
  logic               mem_ready;
  logic               mem_req;
  logic               mem_addr_sel;
  logic               mem_write;

  modport master (
    input  instr_in,
    input  mem_ready,
    output mem_req,
    output mem_addr_sel,
    output mem_write
  );

  modport slave (
    output instr_in,
    output mem_ready,
    input  mem_req,
    input  mem_addr_sel,
    input  mem_write
  );
endinterface

// File: rtl/cpu_sequencer_timeout.sv
// seq_timeout
// Saturating wait counter for memory accesses.
//   clk, rst : clock, synchronous active-high reset
//   clear    : zero the counter (state entry); wins over enable
//   enable   : count one more cycle without mem_ready
//   expired  : the current cycle is the LIMIT-th consecutive waiting cycle
//              (or later); the owner faults if mem_ready is still absent
module seq_timeout #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(LIMIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (enable && (count_reg != CNT_MAX)) begin
      count_next = count_reg + 1'b1;  // saturates at LIMIT, never wraps
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // count_reg holds the waiting cycles already spent, so the LIMIT-th
  // waiting cycle is the one that sees LIMIT-1.
  assign expired = (count_reg >= CNT_LAST);

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer
// Multi-cycle instruction sequencer: FETCH, FETCH_WAIT, DECODE, EXEC, MEM,
// WB, HALT, FAULT. Drives memory handshake, IR capture, PC and writeback
// strobes, with a memory timeout that traps into FAULT.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   mem           : memory handshake (cpu_sequencer_if.master)
//   branch_taken  : branch compare result, valid in EXEC
//   halt_req      : stop at the next instruction boundary
//   step          : (WF8_SINGLE_STEP_EN only) run one instruction from HALT
//   ir_load       : capture instr_in into IR
//   opcode        : latched opcode, IR[INSTR_W-1 -: 5]
//   pc_inc/pc_load: PC+1 / PC<-ALU result (never together)
//   reg_we        : register-file writeback strobe
//   halted, fault : status flags
// Optional feature macro: WF8_SINGLE_STEP_EN.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int INSTR_W     = INSTR_W_DEFAULT,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  cpu_sequencer_if.master       mem,
  input  logic                  branch_taken,
  input  logic                  halt_req,
`ifdef WF8_SINGLE_STEP_EN
  input  logic                  step,
`endif
  output logic                  ir_load,
  output logic [4:0]            opcode,
  output logic                  pc_inc,
  output logic                  pc_load,
  output logic                  reg_we,
  output logic                  halted,
  output logic                  fault
);

  state_t             state_reg;
  state_t             state_next;
  logic [INSTR_W-1:0] ir_reg;
  logic               reset_hold_reg;
  logic               stop_at_boundary;
  state_t             boundary_state;
  opc_class_t         cls;
  logic               expired;
  logic               wait_clear;
  logic               wait_enable;
  logic               mem_req_c;
  logic               mem_addr_sel_c;
  logic               mem_write_c;

  assign opcode = ir_reg[INSTR_W-1 -: 5];
  assign cls    = opc_class(opcode);

  // Operand bits of IR are carried for the datapath but not decoded here.
  generate
    if (INSTR_W > 5) begin : g_ir_operand
      logic unused_ir_operand;
      assign unused_ir_operand = ^ir_reg[INSTR_W-6:0];
    end
  endgenerate

`ifdef WF8_SINGLE_STEP_EN
  logic step_active_reg;
  assign stop_at_boundary = halt_req | step_active_reg;
`else
  assign stop_at_boundary = halt_req;
`endif

  // halt_req is only looked at when the sequencer would re-enter FETCH.
  assign boundary_state = stop_at_boundary ? ST_HALT : ST_FETCH;

  always_comb begin
    state_next     = state_reg;
    mem_req_c      = 1'b0;
    mem_addr_sel_c = 1'b0;
    mem_write_c    = 1'b0;
    ir_load        = 1'b0;
    pc_inc         = 1'b0;
    pc_load        = 1'b0;
    reg_we         = 1'b0;
    halted         = 1'b0;
    fault          = 1'b0;
    unique case (state_reg)
      ST_FETCH: begin
        // The first cycle after reset is quiet so an abandoned access is
        // visibly dropped before a new request is issued.
        if (!reset_hold_reg) begin
          mem_req_c  = 1'b1;
          state_next = ST_FETCH_WAIT;
        end
      end
      ST_FETCH_WAIT: begin
        mem_req_c = 1'b1;
        if (mem.mem_ready) begin
          ir_load    = 1'b1;
          pc_inc     = 1'b1;
          state_next = ST_DECODE;
        end else if (expired) begin
          state_next = ST_FAULT;
        end
      end
      ST_DECODE: begin
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        unique case (cls)
          CLS_LOAD, CLS_STORE: state_next = ST_MEM;
          CLS_JUMP: begin
            pc_load    = 1'b1;
            state_next = boundary_state;
          end
          CLS_BRANCH: begin
            pc_load    = branch_taken;
            state_next = boundary_state;
          end
          default: state_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        mem_req_c      = 1'b1;
        mem_addr_sel_c = 1'b1;
        mem_write_c    = (cls == CLS_STORE);
        if (mem.mem_ready) begin
          state_next = (cls == CLS_LOAD) ? ST_WB : boundary_state;
        end else if (expired) begin
          state_next = ST_FAULT;
        end
      end
      ST_WB: begin
        reg_we     = 1'b1;
        state_next = boundary_state;
      end
      ST_HALT: begin
        halted = 1'b1;
`ifdef WF8_SINGLE_STEP_EN
        if (step || !halt_req) begin
          state_next = ST_FETCH;
        end
`else
        if (!halt_req) begin
          state_next = ST_FETCH;
        end
`endif
      end
      ST_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_next = ST_FAULT;
      end
    endcase
  end

  assign mem.mem_req      = mem_req_c;
  assign mem.mem_addr_sel = mem_addr_sel_c;
  assign mem.mem_write    = mem_write_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_FETCH;
      ir_reg         <= '0;
      reset_hold_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      reset_hold_reg <= 1'b0;
      if (ir_load) begin
        ir_reg <= mem.instr_in;
      end
    end
  end

`ifdef WF8_SINGLE_STEP_EN
  // Remembers that the running instruction was launched by a step pulse so
  // that its boundary returns to HALT even if halt_req has dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_active_reg <= 1'b0;
    end else if (state_reg == ST_HALT && step) begin
      step_active_reg <= 1'b1;
    end else if (state_next == ST_HALT) begin
      step_active_reg <= 1'b0;
    end
  end
`endif

  // Counter restarts on every state change; it only advances while an
  // access is outstanding and memory has not answered.
  assign wait_clear  = (state_next != state_reg);
  assign wait_enable = ((state_reg == ST_FETCH_WAIT) || (state_reg == ST_MEM))
                       && !mem.mem_ready;

  seq_timeout #(
    .LIMIT (MEM_TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (wait_clear),
    .enable  (wait_enable),
    .expired (expired)
  );

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer
// Directed bench for cpu_sequencer. Each cycle the expected output vector
// {mem_req, mem_addr_sel, mem_write, ir_load, pc_inc, pc_load, reg_we,
// halted, fault} is queued when inputs are driven, then popped and compared
// at the falling edge. Define WF8_SINGLE_STEP_EN to include the step checks.
module tb_cpu_sequencer;

  localparam logic [8:0] E_NONE = 9'h000;
  localparam logic [8:0] B_MREQ = 9'h100;
  localparam logic [8:0] B_ASEL = 9'h080;
  localparam logic [8:0] B_MWR  = 9'h040;
  localparam logic [8:0] B_IRL  = 9'h020;
  localparam logic [8:0] B_PCI  = 9'h010;
  localparam logic [8:0] B_PCL  = 9'h008;
  localparam logic [8:0] B_WE   = 9'h004;
  localparam logic [8:0] B_HLT  = 9'h002;
  localparam logic [8:0] B_FLT  = 9'h001;
  localparam logic [8:0] E_FW   = B_MREQ | B_IRL | B_PCI;

  localparam logic [7:0] I_ADD    = 8'h08;  // opcode 00001
  localparam logic [7:0] I_LB     = 8'h90;  // opcode 10010
  localparam logic [7:0] I_SB     = 8'hA0;  // opcode 10100
  localparam logic [7:0] I_JMPADR = 8'hB0;  // opcode 10110
  localparam logic [7:0] I_BRANCH = 8'hC0;  // opcode 11000

  logic       clk = 1'b0;
  logic       rst;
  logic       branch_taken;
  logic       halt_req;
`ifdef WF8_SINGLE_STEP_EN
  logic       step;
`endif
  logic       ir_load;
  logic [4:0] opcode;
  logic       pc_inc;
  logic       pc_load;
  logic       reg_we;
  logic       halted;
  logic       fault;

  always #5 clk = ~clk;

  cpu_sequencer_if #(.INSTR_W(8)) bus ();

  cpu_sequencer #(
    .INSTR_W     (8),
    .MEM_TIMEOUT (15)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem          (bus.master),
    .branch_taken (branch_taken),
    .halt_req     (halt_req),
`ifdef WF8_SINGLE_STEP_EN
    .step         (step),
`endif
    .ir_load      (ir_load),
    .opcode       (opcode),
    .pc_inc       (pc_inc),
    .pc_load      (pc_load),
    .reg_we       (reg_we),
    .halted       (halted),
    .fault        (fault)
  );

  typedef struct {
    string      tag;
    logic [8:0] vec;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  function automatic logic [8:0] observed();
    return {bus.mem_req, bus.mem_addr_sel, bus.mem_write, ir_load, pc_inc,
            pc_load, reg_we, halted, fault};
  endfunction

  task automatic check_out();
    exp_t       e;
    logic [8:0] obs;
    e   = sb_q.pop_front();
    obs = observed();
    tests_run++;
    assert (obs === e.vec) else begin
      tests_failed++;
      $error("FAIL %s: observed %b expected %b", e.tag, obs, e.vec);
    end
  endtask

  // One clock cycle: drive inputs, queue the expectation, compare at negedge.
  // Entered and left #1 after a rising edge.
  task automatic cyc(input logic rdy, input logic bt, input logic hr,
                     input logic [8:0] exp, input string tag);
    exp_t e;
    bus.mem_ready = rdy;
    branch_taken  = bt;
    halt_req      = hr;
    e.tag = tag;
    e.vec = exp;
    sb_q.push_back(e);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  task automatic check_opc(input logic [4:0] exp, input string tag);
    tests_run++;
    assert (opcode === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed opcode %b expected %b", tag, opcode, exp);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.instr_in  = I_ADD;
    bus.mem_ready = 1'b0;
    branch_taken  = 1'b0;
    halt_req      = 1'b0;
`ifdef WF8_SINGLE_STEP_EN
    step          = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    cyc(1, 0, 0, E_NONE, "reset_outputs");
    check_opc(5'b00000, "reset_opcode");
    rst = 1'b0;
    cyc(1, 0, 0, E_NONE, "post_reset_quiet");

    // add, zero-wait memory: ir_load cycle 2, reg_we cycle 5, mem_req cycle 6
    bus.instr_in = I_ADD;
    cyc(1, 0, 0, B_MREQ, "add_c1_fetch");
    cyc(1, 0, 0, E_FW,   "add_c2_ir_load");
    check_opc(5'b00001, "add_opcode");
    cyc(1, 0, 0, E_NONE, "add_c3_decode");
    cyc(1, 0, 0, E_NONE, "add_c4_exec");
    cyc(1, 0, 0, B_WE,   "add_c5_reg_we");

    // lb: six cycles, writeback after MEM
    bus.instr_in = I_LB;
    cyc(1, 0, 0, B_MREQ,          "lb_c1_fetch");
    cyc(1, 0, 0, E_FW,            "lb_c2_ir_load");
    check_opc(5'b10010, "lb_opcode");
    cyc(1, 0, 0, E_NONE,          "lb_c3_decode");
    cyc(1, 0, 0, E_NONE,          "lb_c4_exec");
    cyc(1, 0, 0, B_MREQ | B_ASEL, "lb_c5_mem");
    cyc(1, 0, 0, B_WE,            "lb_c6_wb");

    // sb with three wait cycles in MEM: mem_write for four cycles, no reg_we
    bus.instr_in = I_SB;
    cyc(1, 0, 0, B_MREQ, "sb_fetch");
    cyc(1, 0, 0, E_FW,   "sb_ir_load");
    cyc(1, 0, 0, E_NONE, "sb_decode");
    cyc(1, 0, 0, E_NONE, "sb_exec");
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, B_MREQ | B_ASEL | B_MWR, $sformatf("sb_mem_wait%0d", i));
    end
    cyc(1, 0, 0, B_MREQ | B_ASEL | B_MWR, "sb_mem_ready");

    // branch not taken, branch taken, unconditional jmpadr
    bus.instr_in = I_BRANCH;
    cyc(1, 0, 0, B_MREQ, "br_nt_fetch");
    cyc(1, 0, 0, E_FW,   "br_nt_ir_load");
    cyc(1, 0, 0, E_NONE, "br_nt_decode");
    cyc(1, 0, 0, E_NONE, "br_nt_exec");
    cyc(1, 0, 0, B_MREQ, "br_t_fetch");
    cyc(1, 0, 0, E_FW,   "br_t_ir_load");
    cyc(1, 1, 0, E_NONE, "br_t_decode");
    cyc(1, 1, 0, B_PCL,  "br_t_exec_pc_load");
    bus.instr_in = I_JMPADR;
    cyc(1, 0, 0, B_MREQ, "jmp_fetch");
    cyc(1, 0, 0, E_FW,   "jmp_ir_load");
    check_opc(5'b10110, "jmp_opcode");
    cyc(1, 0, 0, E_NONE, "jmp_decode");
    cyc(1, 0, 0, B_PCL,  "jmp_exec_pc_load");

    // halt at instruction boundary
    bus.instr_in = I_ADD;
    cyc(1, 0, 0, B_MREQ, "halt_fetch");
    cyc(1, 0, 0, E_FW,   "halt_ir_load");
    cyc(1, 0, 0, E_NONE, "halt_decode");
    cyc(1, 0, 0, E_NONE, "halt_exec");
    cyc(1, 0, 1, B_WE,   "halt_wb");
    cyc(1, 0, 1, B_HLT,  "halted_a");
    cyc(1, 0, 1, B_HLT,  "halted_b");
`ifdef WF8_SINGLE_STEP_EN
    step = 1'b1;
    cyc(1, 0, 1, B_HLT,  "step_pulse");
    step = 1'b0;
    cyc(1, 0, 1, B_MREQ, "step_fetch");
    cyc(1, 0, 1, E_FW,   "step_ir_load");
    cyc(1, 0, 1, E_NONE, "step_decode");
    cyc(1, 0, 1, E_NONE, "step_exec");
    cyc(1, 0, 1, B_WE,   "step_wb");
    cyc(1, 0, 1, B_HLT,  "step_rehalt");
    cyc(1, 0, 1, B_HLT,  "step_no_second_fetch");
`endif
    cyc(1, 0, 0, B_HLT,  "halt_release");

    // mem_ready arriving on the expiry cycle completes the access
    cyc(0, 0, 0, B_MREQ, "edge_fetch");
    for (int i = 0; i < 14; i++) begin
      cyc(0, 0, 0, B_MREQ, $sformatf("edge_wait%0d", i));
    end
    cyc(1, 0, 0, E_FW,   "edge_ready_at_expiry");
    cyc(0, 0, 0, E_NONE, "edge_decode");
    cyc(0, 0, 0, E_NONE, "edge_exec");
    cyc(0, 0, 0, B_WE,   "edge_wb");

    // 15 cycles without mem_ready in FETCH_WAIT -> FAULT, held until rst
    cyc(0, 0, 0, B_MREQ, "to_fetch");
    for (int i = 0; i < 15; i++) begin
      cyc(0, 0, 0, B_MREQ, $sformatf("to_wait%0d", i));
    end
    cyc(0, 0, 0, B_FLT, "to_fault");
    cyc(1, 0, 0, B_FLT, "to_fault_sticky_ready");
    cyc(1, 0, 1, B_FLT, "to_fault_sticky_halt");
    rst = 1'b1;
    cyc(1, 0, 0, B_FLT,  "to_fault_during_rst");
    rst = 1'b0;
    cyc(1, 0, 0, E_NONE, "to_after_rst");

    // rst during MEM: FETCH next, no mem_req the cycle after rst
    bus.instr_in = I_LB;
    cyc(1, 0, 0, B_MREQ,          "rm_fetch");
    cyc(1, 0, 0, E_FW,            "rm_ir_load");
    cyc(1, 0, 0, E_NONE,          "rm_decode");
    cyc(0, 0, 0, E_NONE,          "rm_exec");
    cyc(0, 0, 0, B_MREQ | B_ASEL, "rm_mem_wait");
    rst = 1'b1;
    cyc(0, 0, 0, B_MREQ | B_ASEL, "rm_mem_rst");
    rst = 1'b0;
    cyc(1, 0, 0, E_NONE, "rm_mem_req_dropped");
    check_opc(5'b00000, "rm_opcode_cleared");
    cyc(1, 0, 0, B_MREQ, "rm_refetch");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Bound on total run time so a stuck bench always ends with a report.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
